dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-side responder for the MEM stage. It services the dmemREN/dmemWEN/dmemaddr/dmemstore
//   requests issued by the EX/MEM pipeline register, and returns dmemload plus a one-cycle dhit.
// - Holds a word-addressed RAM and inserts a programmable wait-state latency. This lets the
//   pipeline's dhit-driven stall and enable logic run against realistic memory timing.
// PARAMETERS
// - WORDS  256  RAM depth in 32-bit words; power of two, 4..4096
// - LAT    2    wait cycles between request acceptance and dhit; 0..15
// PORTS
// - CLK        in   1   clock; all state changes on the rising edge
// - RST        in   1   reset; synchronous and active-high
// - dmemREN    in   1   read request (from EX/MEM)
// - dmemWEN    in   1   write request (from EX/MEM)
// - dmemaddr   in   32  byte address; word index = dmemaddr[clog2(WORDS)+1:2]
// - dmemstore  in   32  write data
// - datomic    in   1   LL/SC qualifier; present only with DRESP_LLSC_EN
// - dhit       out  1   request complete; high for exactly one cycle
// - dmemload   out  32  read data (SC status when atomic); valid only while dhit=1
// - derr       out  1   misaligned access (dmemaddr[1:0]!=0); pulses together with dhit
// BEHAVIOUR
// - Reset: state IDLE, dhit=0, dmemload=0, derr=0, wait counter=0, link valid=0.
//   RAM contents are not cleared. A reset mid-request abandons that request and performs no write.
// - FSM states: IDLE, WAIT, HIT.
// - IDLE: dmemREN|dmemWEN sampled high -> latch op, address and data; counter<=LAT.
//   Next state is WAIT, or HIT when LAT=0.
// - Both dmemREN and dmemWEN high: the request is treated as a write.
// - WAIT: counter decrements each cycle; counter==1 -> HIT.
//   Request dropped (dmemREN=dmemWEN=0, e.g. EX/MEM flush) -> IDLE, no write, no dhit.
// - HIT: dhit=1. Read: dmemload=RAM[idx].
//   Write: RAM[idx]<=latched data at the end of this cycle; dmemload=0.
//   Next state is always IDLE.
// - Latency: request first seen in cycle 0 -> dhit in cycle LAT+1.
//   Back-to-back throughput is one access per LAT+2 cycles.
// - Requests are latched at acceptance; later changes to addr/data during WAIT are ignored.
// - The requester changes or drops the request in the cycle after dhit. The cycle after HIT is
//   always IDLE and samples fresh inputs, so a held request is serviced again.
// - Misaligned: dhit is still given and derr=1 in the HIT cycle. Writes are suppressed;
//   reads return RAM[idx] (low address bits ignored).
// - Address bits above clog2(WORDS)+1 are ignored; accesses alias modulo WORDS*4 bytes.
// - Read-after-write to the same word in consecutive requests returns the new data
//   (the write has committed before the next HIT).
// CONFIGURATION
// - DRESP_LLSC_EN defined: adds the datomic port plus a link register (address + valid bit).
//   - LL (REN & datomic): normal read; at HIT, link<=idx and valid<=1.
//   - SC (WEN & datomic): at HIT, if valid and the link address equals idx, the write commits
//     and dmemload=1; otherwise there is no write and dmemload=0. Every SC clears valid.
//   - A plain committed write to the linked idx clears valid. Misaligned SC fails with dmemload=0.
// - DRESP_LLSC_EN undefined: no datomic port and no link state; every access is plain.
// TESTING
// - LAT=2, write 0xDEADBEEF to 0x40 then read 0x40:
//   -> dhit in cycle 3 of each request; read dmemload=0xDEADBEEF.
// - LAT=0, REN to 0x8 held constant -> dhit in cycle 1, then IDLE, then dhit again 2 cycles later.
// - LAT=3, drop REN in first WAIT cycle -> no dhit for 4 cycles, state IDLE, RAM unchanged.
// - Write 0x11111111 to 0x42 (misaligned) -> dhit=1, derr=1 same cycle; reading 0x40 returns
//   its prior value.
// - RST asserted during WAIT of a write to 0x80 -> dhit stays 0, outputs 0 next cycle,
//   word at 0x80 unchanged.
// - DRESP_LLSC_EN: LL 0x100, SC 0x100 data 5 -> dmemload=1, RAM=5.
//   Repeating the SC -> dmemload=0, RAM stays 5.
//   LL, then plain SW to 0x100, then SC -> dmemload=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory model for the MEM stage.
// Word-addressed RAM with a programmable wait-state latency and a single-cycle dhit.
// Optional LL/SC support (datomic port and link register) is enabled by defining
// the macro DRESP_LLSC_EN; the default build has neither.
module dmem_responder #(
    parameter int WORDS = 256,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
`ifdef DRESP_LLSC_EN
    input  logic        datomic,
`endif
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        derr
);

    localparam int         AW    = $clog2(WORDS);
    localparam logic [3:0] LAT_L = 4'(LAT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HIT} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            op_wr;
    logic            op_atomic;
    logic            op_mis;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_data;
    logic            mem_we;
    logic            req;
    logic            req_atomic;
    logic            sc_ok;
    logic [31:0]     mem [WORDS];

    // Address bits above the RAM span alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^dmemaddr[31:AW+2];

    assign req = dmemREN | dmemWEN;

`ifdef DRESP_LLSC_EN
    logic [AW-1:0] link_idx;
    logic          link_valid;

    assign req_atomic = datomic;
    assign sc_ok      = link_valid && (link_idx == op_idx) && !op_mis;

    // Link register: set by LL, cleared by any SC or by a plain write to the linked word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_idx   <= '0;
        end else if (state == S_HIT) begin
            if (!op_wr && op_atomic) begin
                link_idx   <= op_idx;
                link_valid <= 1'b1;
            end else if (op_wr && op_atomic) begin
                link_valid <= 1'b0;
            end else if (mem_we && (op_idx == link_idx)) begin
                link_valid <= 1'b0;
            end
        end
    end
`else
    assign req_atomic = 1'b0;
    assign sc_ok      = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Request latch and wait counter; the request is frozen at acceptance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            op_wr     <= 1'b0;
            op_atomic <= 1'b0;
            op_mis    <= 1'b0;
            op_idx    <= '0;
            op_data   <= '0;
        end else if (state == S_IDLE && req) begin
            cnt       <= LAT_L;
            op_wr     <= dmemWEN;
            op_atomic <= req_atomic;
            op_mis    <= (dmemaddr[1:0] != 2'b00);
            op_idx    <= dmemaddr[AW+1:2];
            op_data   <= dmemstore;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Next state, handshake outputs and RAM write enable.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nxt = state;
        dhit      = 1'b0;
        derr      = 1'b0;
        dmemload  = '0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = (LAT == 0) ? S_HIT : S_WAIT;
            end
            S_WAIT: begin
                if (!req)             state_nxt = S_IDLE;
                else if (cnt == 4'd1) state_nxt = S_HIT;
            end
            S_HIT: begin
                dhit      = 1'b1;
                derr      = op_mis;
                state_nxt = S_IDLE;
                if (op_wr) begin
                    if (op_atomic) begin
                        dmemload = {31'b0, sc_ok};
                        mem_we   = sc_ok;
                    end else begin
                        mem_we = !op_mis;
                    end
                end else begin
                    dmemload = mem[op_idx];
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM write port; a reset in the HIT cycle abandons the write.
    always_ff @(posedge CLK) begin
        // NOTE: RAM contents are deliberately not reset; only control state is.
        if (mem_we && !RST) mem[op_idx] <= op_data;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LAT=2, LAT=0, LAT=3).
// Index 0 runs the table of vectors; 1 and 2 cover latency-specific corner cases.
// LL/SC sequences are compiled in only when DRESP_LLSC_EN is defined.
module tb_dmem_responder;

    logic        CLK;
    logic        RST;
    logic        ren   [3];
    logic        wen   [3];
    logic        atom  [3];
    logic [31:0] addr  [3];
    logic [31:0] store [3];
    logic        hit   [3];
    logic [31:0] load  [3];
    logic        err   [3];

    int total = 0;
    int bad   = 0;

    dmem_responder #(.WORDS(256), .LAT(2)) u_dut_l2 (
        .CLK(CLK), .RST(RST), .dmemREN(ren[0]), .dmemWEN(wen[0]),
        .dmemaddr(addr[0]), .dmemstore(store[0]),
`ifdef DRESP_LLSC_EN
        .datomic(atom[0]),
`endif
        .dhit(hit[0]), .dmemload(load[0]), .derr(err[0]));

    dmem_responder #(.WORDS(256), .LAT(0)) u_dut_l0 (
        .CLK(CLK), .RST(RST), .dmemREN(ren[1]), .dmemWEN(wen[1]),
        .dmemaddr(addr[1]), .dmemstore(store[1]),
`ifdef DRESP_LLSC_EN
        .datomic(atom[1]),
`endif
        .dhit(hit[1]), .dmemload(load[1]), .derr(err[1]));

    dmem_responder #(.WORDS(256), .LAT(3)) u_dut_l3 (
        .CLK(CLK), .RST(RST), .dmemREN(ren[2]), .dmemWEN(wen[2]),
        .dmemaddr(addr[2]), .dmemstore(store[2]),
`ifdef DRESP_LLSC_EN
        .datomic(atom[2]),
`endif
        .dhit(hit[2]), .dmemload(load[2]), .derr(err[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on instance sel; returns dhit latency (-1 on timeout), load and err.
    task automatic do_req(input int sel, input logic w, input logic r, input logic at,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] ld, output logic er, output int lt);
        @(negedge CLK);
        wen[sel]   = w;
        ren[sel]   = r;
        atom[sel]  = at;
        addr[sel]  = a;
        store[sel] = d;
        lt = -1;
        ld = '0;
        er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (hit[sel]) begin
                lt = c;
                ld = load[sel];
                er = err[sel];
                break;
            end
        end
        wen[sel]  = 1'b0;
        ren[sel]  = 1'b0;
        atom[sel] = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_load;
        logic        exp_err;
    } vec_t;

    vec_t        vt [12];
    logic [31:0] ld;
    logic        er;
    int          lt;

    initial begin
        // Table for the LAT=2 instance: each row is one request, dhit expected in cycle 3.
        vt[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 32'h0000_0044, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_0042, 32'h1111_1111, 32'h0000_0000, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 32'h0000_0043, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 32'h0000_0448, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 32'h0000_0048, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 32'h0000_004C, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vt[10] = '{1'b0, 1'b1, 32'h0000_004C, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vt[11] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0000_0000, 32'h1234_5678, 1'b0};

        for (int i = 0; i < 3; i++) begin
            ren[i] = 1'b0; wen[i] = 1'b0; atom[i] = 1'b0;
            addr[i] = '0; store[i] = '0;
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset dhit[%0d]", i), 32'(hit[i]), 32'h0);
            check($sformatf("reset dmemload[%0d]", i), load[i], 32'h0);
            check($sformatf("reset derr[%0d]", i), 32'(err[i]), 32'h0);
        end
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_req(0, vt[i].w, vt[i].r, 1'b0, vt[i].a, vt[i].d, ld, er, lt);
            check($sformatf("v%0d latency", i), 32'(lt), 32'd3);
            check($sformatf("v%0d dmemload", i), ld, vt[i].exp_load);
            check($sformatf("v%0d derr", i), 32'(er), 32'(vt[i].exp_err));
        end

        // The cycle after HIT is idle with quiet outputs.
        @(negedge CLK);
        check("idle dhit", 32'(hit[0]), 32'h0);
        check("idle dmemload", load[0], 32'h0);

        // Reset during WAIT of a write to 0x80: the write is abandoned.
        do_req(0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h55AA_55AA, ld, er, lt);
        check("rst pre-write latency", 32'(lt), 32'd3);
        @(negedge CLK);
        wen[0] = 1'b1; addr[0] = 32'h80; store[0] = 32'h9999_9999;
        @(negedge CLK);
        check("rst wait dhit", 32'(hit[0]), 32'h0);
        RST = 1'b1;
        wen[0] = 1'b0;
        @(negedge CLK);
        check("rst mid dhit", 32'(hit[0]), 32'h0);
        check("rst mid dmemload", load[0], 32'h0);
        check("rst mid derr", 32'(err[0]), 32'h0);
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check($sformatf("rst after dhit c%0d", c), 32'(hit[0]), 32'h0);
        end
        do_req(0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, ld, er, lt);
        check("rst readback latency", 32'(lt), 32'd3);
        check("rst readback data", ld, 32'h55AA_55AA);

        // LAT=0: held read gives dhit in cycle 1, idle, dhit again two cycles later.
        do_req(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0808_0808, ld, er, lt);
        check("l0 write latency", 32'(lt), 32'd1);
        @(negedge CLK);
        ren[1] = 1'b1; addr[1] = 32'h8;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            check($sformatf("l0 held dhit c%0d", c), 32'(hit[1]), 32'(c % 2));
            if (c % 2 == 1) check($sformatf("l0 held load c%0d", c), load[1], 32'h0808_0808);
        end
        ren[1] = 1'b0;

        // LAT=3: request dropped in the first WAIT cycle is discarded.
        do_req(2, 1'b1, 1'b0, 1'b0, 32'h20, 32'h3333_3333, ld, er, lt);
        check("l3 write latency", 32'(lt), 32'd4);
        @(negedge CLK);
        wen[2] = 1'b1; addr[2] = 32'h20; store[2] = 32'h7777_7777;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            check($sformatf("l3 drop dhit c%0d", c), 32'(hit[2]), 32'h0);
            if (c == 1) wen[2] = 1'b0;
        end
        do_req(2, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, ld, er, lt);
        check("l3 readback latency", 32'(lt), 32'd4);
        check("l3 readback data", ld, 32'h3333_3333);

`ifdef DRESP_LLSC_EN
        // LL/SC on the LAT=2 instance.
        do_req(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, ld, er, lt);
        do_req(0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, ld, er, lt);
        check("ll load", ld, 32'h0);
        do_req(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h5, ld, er, lt);
        check("sc1 status", ld, 32'h1);
        do_req(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, ld, er, lt);
        check("sc1 ram", ld, 32'h5);
        do_req(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h7, ld, er, lt);
        check("sc2 status", ld, 32'h0);
        do_req(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, ld, er, lt);
        check("sc2 ram", ld, 32'h5);
        do_req(0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, ld, er, lt);
        do_req(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h9, ld, er, lt);
        do_req(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h6, ld, er, lt);
        check("sc3 status", ld, 32'h0);
        do_req(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, ld, er, lt);
        check("sc3 ram", ld, 32'h9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
